// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front end to data_mem with sub-word RMW and load extension.
// Define MAU_ALIGN_TRAP_EN to trap misaligned requests instead of force-aligning them.
module mem_access_unit #(
  parameter int WIDTH              = 32,
  parameter int DATA_MEM_ADDR_BITS = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [1:0]                    req_size,
  input  logic                          req_unsigned,
  input  logic [WIDTH-1:0]              req_addr,
  input  logic [WIDTH-1:0]              req_wdata,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [WIDTH-1:0]              rsp_rdata,
  output logic                          rsp_err,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [DATA_MEM_ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic [WIDTH-1:0]              mem_rdata
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rword_q, rword_d, rdata_q, rdata_d;
  logic [1:0] size_q, size_d;
  logic we_q, we_d, uns_q, uns_d, err_q, err_d;
  logic half, word, trap;
  logic [WIDTH-1:0] addr_al, ext, lane_mask, merged;
  logic [4:0] sh;
  logic [7:0] b;
  logic [15:0] h;

  assign word = req_size[1];
  assign half = req_size == 2'b01;
`ifdef MAU_ALIGN_TRAP_EN
  assign trap    = (half & req_addr[0]) | (word & |req_addr[1:0]);
  assign addr_al = req_addr;
`else
  assign trap    = 1'b0;
  assign addr_al = {req_addr[WIDTH-1:2], word ? 2'b00 : {req_addr[1], half ? 1'b0 : req_addr[0]}};
`endif

  // Big-endian lanes: offset 0 is the most significant lane, so shift by (3-offset) lanes.
  assign sh        = size_q == 2'b00 ? {~addr_q[1:0], 3'b000} : {~addr_q[1], 4'b0000};
  assign b         = 8'(mem_rdata >> sh);
  assign h         = 16'(mem_rdata >> sh);
  assign ext       = size_q[1] ? mem_rdata
                   : size_q[0] ? {{16{~uns_q & h[15]}}, h} : {{24{~uns_q & b[7]}}, b};
  assign lane_mask = size_q[0] ? 32'h0000_FFFF << sh : 32'h0000_00FF << sh;
  assign merged    = size_q[1] ? wdata_q : (rword_q & ~lane_mask) | ((wdata_q << sh) & lane_mask);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rword_d = rword_q;
    rdata_d = rdata_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: if (req_valid) begin
        addr_d  = addr_al;
        wdata_d = req_wdata;
        size_d  = req_size;
        we_d    = req_we;
        uns_d   = req_unsigned;
        rdata_d = '0;
        err_d   = trap;
        state_d = trap ? RESP : (req_we & word) ? WR : RD;
      end
      RD: begin
        rword_d = mem_rdata;
        rdata_d = we_q ? '0 : ext;
        state_d = we_q ? WR : RESP;
      end
      WR:   state_d = RESP;
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rword_q <= '0;
      rdata_q <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rword_q <= rword_d;
      rdata_q <= rdata_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign mem_en    = (state_q == RD || state_q == WR) & ~reset;
  assign mem_we    = (state_q == WR) & ~reset;
  assign mem_adr   = DATA_MEM_ADDR_BITS'(addr_q >> 2);
  assign mem_wdata = state_q == WR ? merged : '0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a small data_mem model.
module tb_mem_access_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, mem_rdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_en, mem_we;
  logic [31:0] rsp_rdata, mem_adr, mem_wdata;
  logic [31:0] mem [0:15];
  int n_chk = 0, n_fail = 0, en_cnt = 0, we_cnt = 0;
  logic [31:0] rd;
  logic        er;
  int          lat;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_en) mem_rdata <= mem[mem_adr[3:0]];
    if (mem_en) en_cnt = en_cnt + 1;
    if (mem_we) we_cnt = we_cnt + 1;
  end
  always @(posedge clk) if (mem_en && mem_we) mem[mem_adr[3:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] r, output logic e, output int l);
    en_cnt = 0;
    we_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    l = 1;
    while (!rsp_valid && l < 20) begin
      @(posedge clk);
      #1 l++;
    end
    r = rsp_rdata;
    e = rsp_err;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h8899AABB;
    mem[1] = 32'h11223344;
    mem[2] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1;
    check("rst req_ready", {31'b0, req_ready}, 32'd1);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst rsp_rdata", rsp_rdata, 32'h0);
    check("rst rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst mem_en_we", {30'b0, mem_en, mem_we}, 32'd0);
    check("rst mem_adr", mem_adr, 32'h0);
    check("rst mem_wdata", mem_wdata, 32'h0);
    reset = 1'b0;

    do_req(0, 2'b00, 0, 32'd1, 0, rd, er, lat);
    check("LB1 data", rd, 32'hFFFFFF99);
    check("LB1 latency", lat, 2);
    check("LB1 en pulses", en_cnt, 1);
    consume();
    check("LB1 ready after", {31'b0, req_ready}, 32'd1);
    do_req(0, 2'b01, 1, 32'd2, 0, rd, er, lat); check("LHU2 data", rd, 32'h0000AABB); consume();
    do_req(0, 2'b01, 0, 32'd0, 0, rd, er, lat); check("LH0 data", rd, 32'hFFFF8899); consume();
    do_req(0, 2'b10, 1, 32'd0, 0, rd, er, lat); check("LW0 data", rd, 32'h8899AABB); consume();
    do_req(0, 2'b00, 1, 32'd3, 0, rd, er, lat); check("LBU3 data", rd, 32'h000000BB); consume();
    do_req(0, 2'b00, 0, 32'd0, 0, rd, er, lat); check("LB0 data", rd, 32'hFFFFFF88); consume();

    do_req(1, 2'b00, 0, 32'd6, 32'h000000EE, rd, er, lat);
    check("SB6 latency", lat, 3);
    check("SB6 rdata", rd, 32'h0);
    check("SB6 en pulses", en_cnt, 2);
    check("SB6 we pulses", we_cnt, 1);
    consume();
    check("SB6 word1", mem[1], 32'h1122EE44);

    do_req(1, 2'b01, 0, 32'd10, 32'hFFFF5678, rd, er, lat);
    check("SH10 latency", lat, 3);
    consume();
    check("SH10 word2", mem[2], 32'hCAFE5678);

    do_req(1, 2'b10, 0, 32'd4, 32'hDEADBEEF, rd, er, lat);
    check("SW4 latency", lat, 2);
    check("SW4 en pulses", en_cnt, 1);
    check("SW4 we pulses", we_cnt, 1);
    consume();
    check("SW4 word1", mem[1], 32'hDEADBEEF);

    rsp_ready = 1'b0;
    do_req(0, 2'b10, 0, 32'd0, 0, rd, er, lat);
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold rsp_valid", {31'b0, rsp_valid}, 32'd1);
      check("hold rsp_rdata", rsp_rdata, 32'h8899AABB);
      check("hold req_ready", {31'b0, req_ready}, 32'd0);
    end
    check("hold en pulses", en_cnt, 0);
    consume();
    check("hold released", {30'b0, rsp_valid, req_ready}, 32'd1);

    do_req(0, 2'b10, 0, 32'd3, 0, rd, er, lat);
`ifdef MAU_ALIGN_TRAP_EN
    check("LW3 err", {31'b0, er}, 32'd1);
    check("LW3 data", rd, 32'h0);
    check("LW3 latency", lat, 1);
    check("LW3 en pulses", en_cnt, 0);
`else
    check("LW3 err", {31'b0, er}, 32'd0);
    check("LW3 data", rd, 32'h8899AABB);
    check("LW3 latency", lat, 2);
    check("LW3 en pulses", en_cnt, 1);
`endif
    consume();
    do_req(0, 2'b01, 0, 32'd1, 0, rd, er, lat);
`ifdef MAU_ALIGN_TRAP_EN
    check("LH1 err", {31'b0, er}, 32'd1);
    check("LH1 data", rd, 32'h0);
`else
    check("LH1 err", {31'b0, er}, 32'd0);
    check("LH1 data", rd, 32'hFFFF8899);
`endif
    consume();

    en_cnt = 0;
    we_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'd6; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("rstWR we pulses", we_cnt, 0);
    check("rstWR word1", mem[1], 32'hDEADBEEF);
    check("rstWR idle", {30'b0, req_ready, rsp_valid}, 32'd2);
    repeat (3) @(posedge clk);
    #1;
    check("rstWR no rsp", {31'b0, rsp_valid}, 32'd0);

    do_req(0, 2'b10, 0, 32'd4, 0, rd, er, lat);
    check("LW4 after rst", rd, 32'hDEADBEEF);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
